vmem_ctrl: RTL and testbench
============================

VMEM_CTRL -- requirements
Module: vmem_ctrl

Interface
REQ-001 Parameter COLS, default 70: characters per text row, with cursor x in 0..COLS-1.
REQ-002 Parameter ROWS, default 30: text rows, with cursor y in 0..ROWS-1.
REQ-003 Parameter BLINK_CYCLES, default 25_000_000: clk cycles per cursor_on phase.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port key_in, input, 8 bits: ASCII code from the keyboard path.
REQ-007 Port key_valid, input, 1 bit: key_in is valid this cycle.
REQ-008 Port key_ready, output, 1 bit: the block accepts the key this cycle.
REQ-009 Port clr_screen, input, 1 bit: single-cycle request to clear the whole screen.
REQ-010 Port wr_en, output, 1 bit: character memory write strobe.
REQ-011 Port wr_addr, output, 12 bits: write address formed as {x[6:0], y[4:0]}.
REQ-012 Port wr_data, output, 8 bits: write data.
REQ-013 Port cur_x, output, 7 bits: cursor column.
REQ-014 Port cur_y, output, 5 bits: cursor row.
REQ-015 Port busy, output, 1 bit: a clear sequence is in progress.
REQ-016 Port cursor_on, output, 1 bit: cursor visibility for the renderer.

Function
REQ-017 FSM states: IDLE, CLR_ROW, CLR_ALL.
REQ-018 key_ready is 1 only when state is IDLE and clr_screen is 0; a key is accepted when key_valid and key_ready are both 1.
REQ-019 wr_en, wr_addr and wr_data are registered: the write appears exactly 1 cycle after acceptance, and wr_en is 0 in every other cycle unless a clear sequence is writing.
REQ-020 Printable key (any code other than 0x0A and 0x08): write key_in at the pre-advance cursor, then set x to x+1; if x==COLS-1, set x to 0 and advance the row.
REQ-021 ENTER (0x0A): no write; set x to 0 and advance the row.
REQ-022 Backspace (0x08): if x>0, set x to x-1; else if y>0, set x to COLS-1 and y to y-1; write CLEAR_CHAR at the new cursor position.
REQ-023 Backspace at (0,0): no write, no cursor change; the key is still consumed.
REQ-024 Row advance: y becomes y+1, wrapping from ROWS-1 to 0, then the FSM enters CLR_ROW for the new row.
REQ-025 CLR_ROW: write CLEAR_CHAR to columns 0..COLS-1 of row y, one per cycle (COLS writes), with x held at 0, then return to IDLE.
REQ-026 CLR_ALL: write CLEAR_CHAR to all ROWS*COLS cells, column-major within each row, one per cycle; on completion set the cursor to (0,0) and return to IDLE.
REQ-027 clr_screen in IDLE: enter CLR_ALL the next cycle; a simultaneous key_valid is not accepted.
REQ-028 clr_screen during CLR_ROW: abort the row clear and restart as CLR_ALL from cell (0,0).
REQ-029 clr_screen during CLR_ALL: ignored.
REQ-030 busy is 1 exactly when the state is CLR_ROW or CLR_ALL.
REQ-031 All internal counters use full widths, with no wrap beyond COLS-1 or ROWS-1.

Reset
REQ-032 When reset is asserted: state is CLR_ALL, clear counters 0, cursor (0,0), wr_en 0, wr_addr 0, wr_data 0, cursor_on 1.
REQ-033 After reset deasserts, the block performs a full clear (ROWS*COLS writes) before key_ready can rise.
REQ-034 Reset asserted mid-sequence aborts it immediately; no partial write follows reset.

Configuration
REQ-035 Macro VMEM_CURSOR_BLINK_EN, when defined: cursor_on toggles every BLINK_CYCLES cycles and is forced to 1, with the counter restarting, on every accepted key.
REQ-036 Without VMEM_CURSOR_BLINK_EN: cursor_on is constant 1 and no blink counter exists; the port is present either way.

Structure
REQ-037 Package vmem_pkg holds KEY_ENTER=8'h0A, KEY_BS=8'h08, CLEAR_CHAR=8'h00, the default COLS and ROWS, and the FSM state enum.
REQ-038 The blink counter lives in sub-module vmem_cursor_blink, instantiated only under VMEM_CURSOR_BLINK_EN.

Verification
REQ-039 Reset release: exactly 2100 writes of 0x00 with key_ready=0 throughout, then key_ready=1 and cursor (0,0).
REQ-040 Key 0x41 at (0,0): next cycle wr_en=1, wr_addr=12'h000, wr_data=0x41; cursor becomes (1,0).
REQ-041 70 printable keys from (0,0): the last write goes to x=69, then cursor is (0,1), busy=1 for 70 cycles with writes to {x,5'd1} for x=0..69.
REQ-042 ENTER at (5,29): no data write, cursor becomes (0,0), and CLR_ROW clears row 0.
REQ-043 Backspace at (0,3): cursor becomes (69,2) with a 0x00 write to {7'd69,5'd2}; backspace at (0,0) is consumed with no write.
REQ-044 clr_screen asserted with key_valid in the same cycle: key not accepted, then a 2100-write clear, cursor (0,0); clr_screen mid-CLR_ROW restarts the clear at address 0.

Source files
------------

// File: rtl/vmem_pkg.sv
// vmem_pkg: shared key codes, clear character, default geometry and FSM
// state type for the video-memory text controller.
package vmem_pkg;

    localparam logic [7:0] KEY_ENTER  = 8'h0A;
    localparam logic [7:0] KEY_BS     = 8'h08;
    localparam logic [7:0] CLEAR_CHAR = 8'h00;

    localparam int DEF_COLS = 70;
    localparam int DEF_ROWS = 30;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLR_ROW = 2'd1,
        S_CLR_ALL = 2'd2
    } vmem_state_e;

endpackage

// File: rtl/vmem_cursor_blink.sv
// vmem_cursor_blink: cursor visibility toggle driven by a reloading
// down-counter; a restart pulse forces the cursor visible and reloads.
module vmem_cursor_blink #(
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic cursor_on
);

    localparam int CW = $clog2(BLINK_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(BLINK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          on_q, on_d;

    always_comb begin
        cnt_d = cnt_q;
        on_d  = on_q;
        if (restart) begin
            cnt_d = RELOAD;
            on_d  = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d = RELOAD;
            on_d  = ~on_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= RELOAD;
            on_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            on_q  <= on_d;
        end
    end

    assign cursor_on = on_q;

endmodule

// File: rtl/vmem_ctrl.sv
// vmem_ctrl: keyboard-driven text cursor and character-memory writer with
// row and full-screen clear sequences. Cursor blink under VMEM_CURSOR_BLINK_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a key or a clear request
// S_CLR_ROW | blanking row y one column per cycle after a row advance
// S_CLR_ALL | blanking every cell row by row, then cursor home
module vmem_ctrl
    import vmem_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  key_in,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        clr_screen,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy,
    output logic        cursor_on
);

    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

    if (COLS < 1 || COLS > 128 || ROWS < 1 || ROWS > 32 || BLINK_CYCLES < 1) begin : g_param_check
        $error("vmem_ctrl: geometry must fit the 7-bit x / 5-bit y address fields");
    end

    vmem_state_e state_q, state_d;
    logic [6:0]  x_q, x_d, clr_x_q, clr_x_d;
    logic [4:0]  y_q, y_d, clr_y_q, clr_y_d;
    logic        wr_en_q, wr_en_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        key_acc;
    logic        row_adv;

    assign key_ready = (state_q == S_IDLE) && !clr_screen;
    assign key_acc   = key_valid && key_ready;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        clr_x_d   = clr_x_q;
        clr_y_d   = clr_y_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        row_adv   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clr_screen) begin
                    state_d = S_CLR_ALL;
                    clr_x_d = '0;
                    clr_y_d = '0;
                end else if (key_acc) begin
                    if (key_in == KEY_ENTER) begin
                        x_d     = '0;
                        row_adv = 1'b1;
                    end else if (key_in == KEY_BS) begin
                        // At the home position backspace is swallowed silently.
                        if (x_q != '0) begin
                            x_d       = x_q - 7'd1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = {x_q - 7'd1, y_q};
                            wr_data_d = CLEAR_CHAR;
                        end else if (y_q != '0) begin
                            x_d       = X_MAX;
                            y_d       = y_q - 5'd1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = {X_MAX, y_q - 5'd1};
                            wr_data_d = CLEAR_CHAR;
                        end
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {x_q, y_q};
                        wr_data_d = key_in;
                        if (x_q == X_MAX) begin
                            x_d     = '0;
                            row_adv = 1'b1;
                        end else begin
                            x_d = x_q + 7'd1;
                        end
                    end

                    if (row_adv) begin
                        y_d     = (y_q == Y_MAX) ? 5'd0 : y_q + 5'd1;
                        clr_x_d = '0;
                        state_d = S_CLR_ROW;
                    end
                end
            end

            S_CLR_ROW: begin
                if (clr_screen) begin
                    state_d = S_CLR_ALL;
                    clr_x_d = '0;
                    clr_y_d = '0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {clr_x_q, y_q};
                    wr_data_d = CLEAR_CHAR;
                    if (clr_x_q == X_MAX) begin
                        clr_x_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        clr_x_d = clr_x_q + 7'd1;
                    end
                end
            end

            S_CLR_ALL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {clr_x_q, clr_y_q};
                wr_data_d = CLEAR_CHAR;
                if (clr_x_q == X_MAX) begin
                    clr_x_d = '0;
                    if (clr_y_q == Y_MAX) begin
                        clr_y_d = '0;
                        x_d     = '0;
                        y_d     = '0;
                        state_d = S_IDLE;
                    end else begin
                        clr_y_d = clr_y_q + 5'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 7'd1;
                end
            end

            default: begin
                state_d = S_CLR_ALL;
                clr_x_d = '0;
                clr_y_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_CLR_ALL;
            x_q       <= '0;
            y_q       <= '0;
            clr_x_q   <= '0;
            clr_y_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            clr_x_q   <= clr_x_d;
            clr_y_q   <= clr_y_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cur_x   = x_q;
    assign cur_y   = y_q;
    assign busy    = (state_q == S_CLR_ROW) || (state_q == S_CLR_ALL);

`ifdef VMEM_CURSOR_BLINK_EN
    vmem_cursor_blink #(
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_blink (
        .clk      (clk),
        .reset    (reset),
        .restart  (key_acc),
        .cursor_on(cursor_on)
    );
`else
    assign cursor_on = 1'b1;
`endif

endmodule

// File: tb/tb_vmem_ctrl.sv
// tb_vmem_ctrl: directed and randomized key sequences against a screen/cursor
// reference model; writes are scoreboarded in order and the screen is compared.
module tb_vmem_ctrl;
    import vmem_pkg::*;

    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int FULL = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  key_in;
    logic        key_valid;
    logic        key_ready;
    logic        clr_screen;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;
    logic        cursor_on;

    always #5 clk = ~clk;

    vmem_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .clr_screen(clr_screen),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .busy      (busy),
        .cursor_on (cursor_on)
    );

    int npass = 0;
    int nchk  = 0;
    int nwr   = 0;
    int mx    = 0;
    int my    = 0;
    logic [7:0]  scr  [0:4095];
    logic [7:0]  mscr [0:4095];
    logic [19:0] wq[$];
    logic [19:0] eq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            wq.push_back({wr_addr, wr_data});
            scr[wr_addr] = wr_data;
            nwr++;
        end
    endtask

    task automatic exp_wr(input int a, input logic [7:0] d);
        eq.push_back({12'(a), d});
        mscr[a] = d;
    endtask

    task automatic model_row_adv();
        my = (my + 1) % ROWS;
        for (int c = 0; c < COLS; c++) exp_wr(c * 32 + my, 8'h00);
    endtask

    task automatic model_full_clear();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) exp_wr(x * 32 + y, 8'h00);
        mx = 0;
        my = 0;
    endtask

    task automatic cmp_q(input string tag);
        int mism = 0;
        int n;
        n = (wq.size() < eq.size()) ? wq.size() : eq.size();
        for (int i = 0; i < n; i++) if (wq[i] !== eq[i]) mism++;
        chk({tag, "_wr_count"}, wq.size(), eq.size());
        chk({tag, "_wr_seq_mism"}, mism, 0);
        wq.delete();
        eq.delete();
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (key_ready !== 1'b1 && n < 5000) begin
            cycle();
            n++;
        end
        chk({tag, "_ready_in_time"}, (n < 5000), 1);
    endtask

    task automatic send_key(input logic [7:0] k);
        int n;
        bit w;
        int a;
        w = 0;
        a = 0;
        key_in    = k;
        key_valid = 1'b1;
        #1;
        wait_ready("key", n);
        cycle();
        key_valid = 1'b0;
        key_in    = 8'($urandom);
        if (k == KEY_ENTER) begin
            mx = 0;
            model_row_adv();
        end else if (k == KEY_BS) begin
            if (mx > 0) begin
                mx--;
                w = 1;
            end else if (my > 0) begin
                mx = COLS - 1;
                my--;
                w = 1;
            end
            a = mx * 32 + my;
            if (w) begin
                eq.push_back({12'(a), 8'h00});
                mscr[a] = 8'h00;
            end
        end else begin
            w = 1;
            a = mx * 32 + my;
            exp_wr(a, k);
            mx++;
            if (mx == COLS) begin
                mx = 0;
                model_row_adv();
            end
        end
        chk("key_wr_en", wr_en, w);
        if (w) begin
            chk("key_wr_addr", wr_addr, a);
            chk("key_wr_data", wr_data, (k == KEY_BS) ? 8'h00 : k);
        end
        chk("key_cur_x", cur_x, mx);
        chk("key_cur_y", cur_y, my);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int mism;
        key_in     = 8'h00;
        key_valid  = 1'b0;
        clr_screen = 1'b0;
        reset      = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            scr[i]  = 8'hFF;
            mscr[i] = 8'hFF;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cur_x", cur_x, 0);
        chk("rst_cur_y", cur_y, 0);
        chk("rst_busy", busy, 1);
        chk("rst_key_ready", key_ready, 0);
        chk("rst_cursor_on", cursor_on, 1);

        reset = 1'b1;
        model_full_clear();
        n = 0;
        while (key_ready !== 1'b1 && n < 3000) begin
            cycle();
            n++;
        end
        chk("boot_clear_cycles", n, FULL);
        chk("boot_clear_writes", nwr, FULL);
        cmp_q("boot_clear");
        chk("boot_cur_x", cur_x, 0);
        chk("boot_cur_y", cur_y, 0);

        send_key(8'h41);
        chk("k41_addr", wr_addr, 12'h000);
        chk("k41_data", wr_data, 8'h41);
        send_key(KEY_BS);

        for (int i = 0; i < COLS; i++) send_key(rand_print());
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            cycle();
        end
        chk("row_clear_busy_cycles", n, COLS);
        cmp_q("wrap_row1");
        chk("wrap_cur_x", cur_x, 0);
        chk("wrap_cur_y", cur_y, 1);

        for (int i = 0; i < 28; i++) send_key(KEY_ENTER);
        for (int i = 0; i < 5; i++) send_key(rand_print());
        chk("pre_enter_x", cur_x, 5);
        chk("pre_enter_y", cur_y, 29);
        send_key(KEY_ENTER);
        wait_ready("enter_wrap", n);
        cmp_q("enter_wrap");

        for (int i = 0; i < 3; i++) send_key(KEY_ENTER);
        send_key(KEY_BS);
        chk("bs_row_addr", wr_addr, {7'd69, 5'd2});
        for (int i = 0; i < 28; i++) send_key(KEY_ENTER);
        send_key(KEY_BS);
        wait_ready("bs_home", n);
        cmp_q("bs_seq");

        send_key(KEY_ENTER);
        repeat (5) cycle();
        reset = 1'b0;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_cur_y", cur_y, 0);
        @(posedge clk);
        #1;
        chk("midrst_no_write", wr_en, 0);
        wq.delete();
        eq.delete();
        reset = 1'b1;
        model_full_clear();
        base = nwr;
        n = 0;
        while (key_ready !== 1'b1 && n < 3000) begin
            cycle();
            n++;
        end
        chk("midrst_clear_writes", nwr - base, FULL);
        cmp_q("midrst_clear");

        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) send_key(rand_print());
            else if (r < 8) send_key(KEY_ENTER);
            else send_key(KEY_BS);
            repeat ($urandom_range(0, 2)) cycle();
        end
        wait_ready("rand", n);
        cmp_q("rand");

        key_in     = 8'h55;
        key_valid  = 1'b1;
        clr_screen = 1'b1;
        #1;
        chk("clr_key_ready", key_ready, 0);
        cycle();
        clr_screen = 1'b0;
        key_valid  = 1'b0;
        chk("clr_no_key_write", wr_en, 0);
        chk("clr_busy", busy, 1);
        model_full_clear();
        base = nwr;
        wait_ready("clr", n);
        chk("clr_writes", nwr - base, FULL);
        cmp_q("clr");
        chk("clr_cur_x", cur_x, 0);
        chk("clr_cur_y", cur_y, 0);

        send_key(rand_print());
        send_key(KEY_ENTER);
        repeat (10) cycle();
        wq.delete();
        eq.delete();
        clr_screen = 1'b1;
        cycle();
        clr_screen = 1'b0;
        chk("abort_no_write", wr_en, 0);
        model_full_clear();
        base = nwr;
        wait_ready("abort", n);
        chk("abort_restart_addr", (wq.size() > 0) ? 32'(wq[0][19:8]) : 32'hFFFF, 0);
        chk("abort_writes", nwr - base, FULL);
        cmp_q("abort");
        chk("abort_cur_x", cur_x, 0);
        chk("abort_cur_y", cur_y, 0);

        mism = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (scr[x * 32 + y] !== mscr[x * 32 + y]) mism++;
        chk("screen_mism", mism, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
